issue_arbiter: RTL

Shares the single fetch-to-issue path of the MPT pipeline between several independent requesters (e.g. hart-side check ports), ahead of `issue_stage`. Each cycle it picks one valid requester round-robin, registers the request with its source index, and enforces a per-requester cap on outstanding transactions. Completions returned from the PLB-lookup side free those credits. A flush input quiesces the arbiter so software or a reconfiguration sequence can drain the pipeline.

---
 rtl/issue_arbiter_pkg.sv | 12 +
 rtl/issue_arbiter_if.sv | 35 +++
 rtl/issue_arbiter_rr_arbiter.sv | 37 +++
 rtl/issue_arbiter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/issue_arbiter_pkg.sv
// Shared types and default sizing for the issue arbiter.
package issue_arbiter_pkg;

    localparam int ISSUE_ARB_NUM_REQ         = 4;
    localparam int ISSUE_ARB_DATA_WIDTH      = 32;
    localparam int ISSUE_ARB_MAX_OUTSTANDING = 4;
    localparam int ISSUE_ARB_SRC_W           = $clog2(ISSUE_ARB_NUM_REQ);

    // Requester index as carried on issue_src / cpl_src for the default build.
    typedef logic [ISSUE_ARB_SRC_W-1:0] issue_arb_src_t;

endpackage

// File: rtl/issue_arbiter_if.sv
// Requester, issue, completion and status signals of the issue arbiter.
// Names keep the arbiter's point of view (_i driven into it, _o driven by it).
interface issue_arbiter_if
    import issue_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = ISSUE_ARB_NUM_REQ,
    parameter int DATA_WIDTH = ISSUE_ARB_DATA_WIDTH
) ();
    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                 req_valid_i;
    logic [NUM_REQ-1:0]                 req_ready_o;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_i;
    logic                               issue_valid_o;
    logic                               issue_ready_i;
    logic [DATA_WIDTH-1:0]              issue_data_o;
    logic [SRC_W-1:0]                   issue_src_o;
    logic                               cpl_valid_i;
    logic [SRC_W-1:0]                   cpl_src_i;
    logic                               flush_i;
    logic                               drained_o;
    logic                               cpl_err_o;

    // Requesters / issue stage / completion source side.
    modport master (
        output req_valid_i, req_data_i, issue_ready_i, cpl_valid_i, cpl_src_i, flush_i,
        input  req_ready_o, issue_valid_o, issue_data_o, issue_src_o, drained_o, cpl_err_o
    );

    // Arbiter side.
    modport slave (
        input  req_valid_i, req_data_i, issue_ready_i, cpl_valid_i, cpl_src_i, flush_i,
        output req_ready_o, issue_valid_o, issue_data_o, issue_src_o, drained_o, cpl_err_o
    );
endinterface

// File: rtl/issue_arbiter_rr_arbiter.sv
// Combinational pointer-based round-robin arbiter: the first requesting
// index at or after ptr_i (wrapping) wins. Reusable for other arbiters.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 vld_o
);
    localparam int IDX_W = $clog2(N);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Scan priority order ptr, ptr+1, ... wrapping at N; keep the first hit.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr_i} + (IDX_W+1)'(off);
            if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
            cand = sum[IDX_W-1:0];
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
        vld_o = found;
    end
endmodule

// File: rtl/issue_arbiter.sv
// Round-robin arbiter sharing the single issue path between NUM_REQ
// requesters, with a per-requester outstanding-credit cap, a one-entry
// output register (OREG) toward the issue stage, and a flush/drain control.
module issue_arbiter
    import issue_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = ISSUE_ARB_NUM_REQ,
    parameter int DATA_WIDTH      = ISSUE_ARB_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = ISSUE_ARB_MAX_OUTSTANDING
) (
    input logic            clk_i,
    input logic            rst_ni,
    issue_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [SRC_W-1:0]              ptr_q, ptr_d;
    logic                          issue_valid_q, issue_valid_d;
    logic [DATA_WIDTH-1:0]         issue_data_q, issue_data_d;
    logic [SRC_W-1:0]              issue_src_q, issue_src_d;
    logic                          cpl_err_q, cpl_err_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] cpl_hit;
    logic [SRC_W-1:0]   arb_idx;
    logic               arb_vld;
    logic               oreg_free;
    logic               grant;
    logic               cpl_in_range;

    // A requester may compete only with a free credit and while not flushing.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = bus.req_valid_i[i] && (cnt_q[i] < CNT_MAX) && !bus.flush_i;
        end
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i (eligible),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    // OREG can take a new request when empty or being consumed this cycle.
    assign oreg_free = !issue_valid_q || bus.issue_ready_i;
    assign grant     = oreg_free && arb_vld;
    assign req_ready = grant ? arb_gnt : '0;

    assign cpl_in_range = ({1'b0, bus.cpl_src_i} < (SRC_W+1)'(NUM_REQ));

    // Decode which requester a completion targets.
    always_comb begin
        cpl_hit = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cpl_hit[i] = bus.cpl_valid_i && cpl_in_range && (bus.cpl_src_i == SRC_W'(i));
        end
    end

    // Credit counters: +1 on accept, -1 on completion; a completion for an
    // empty counter or an unknown source is flagged instead of underflowing.
    always_comb begin
        cnt_d     = cnt_q;
        cpl_err_d = cpl_err_q;
        if (bus.cpl_valid_i && !cpl_in_range) cpl_err_d = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cpl_hit[i] && cnt_q[i] == '0) cpl_err_d = 1'b1;
            unique case ({req_ready[i], cpl_hit[i] && cnt_q[i] != '0})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // Pointer moves just past the winner so it gets lowest priority next.
    always_comb begin
        ptr_d = ptr_q;
        if (grant) ptr_d = (arb_idx == LAST_IDX) ? '0 : arb_idx + SRC_W'(1);
    end

    // OREG: load on grant, hold while stalled, empty when consumed without refill.
    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_data_d  = issue_data_q;
        issue_src_d   = issue_src_q;
        if (oreg_free) begin
            issue_valid_d = grant;
            if (grant) begin
                issue_data_d = bus.req_data_i[arb_idx];
                issue_src_d  = arb_idx;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q         <= '0;
            ptr_q         <= '0;
            issue_valid_q <= 1'b0;
            issue_data_q  <= '0;
            issue_src_q   <= '0;
            cpl_err_q     <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            issue_valid_q <= issue_valid_d;
            issue_data_q  <= issue_data_d;
            issue_src_q   <= issue_src_d;
            cpl_err_q     <= cpl_err_d;
        end
    end

    assign bus.req_ready_o   = req_ready;
    assign bus.issue_valid_o = issue_valid_q;
    assign bus.issue_data_o  = issue_data_q;
    assign bus.issue_src_o   = issue_src_q;
    assign bus.cpl_err_o     = cpl_err_q;
    assign bus.drained_o     = !issue_valid_q && (cnt_q == '0);

endmodule
